mtr_incr_sched: RTL
===================

Name: mtr_incr_sched

Overview:
- Schedules meter-board service requests toward the PI system.
- Four hardware counters (TIME, PERF, EBOX, CACHE) each raise a one-cycle overflow pulse when their low-order half wraps into bit 2. The interval timer raises a done level.
- The block latches these requests, picks one by fixed priority, and runs the PI request / honor / microcode-service handshake.
- It emits INCR_SEL / VECTOR_REQ to the EBUS read mux, and a clear strobe back to the serviced counter.

Parameters:
- HONOR_TMO, 64, cycles in REQ without honor before the request is withdrawn for one cycle and re-arbitrated. Legal range 2..255.
- TMO_W, 8, width of the timeout counter.

Ports:
- clk  in  1  MBOX clock; every flop is posedge clk.
- RESET  in  1  synchronous, active-high reset.
- OVF  in  4  [0:3] = TIME, PERF, EBOX, CACHE overflow pulses, one cycle each.
- INTV_DONE  in  1  interval done level.
- PIA  in  3  meter PI assignment; 0 disables interrupts.
- HONOR  in  1  PI honors the meter request; one-cycle pulse.
- SERVICE_DONE  in  1  microcode has finished the memory add or vector dispatch; one-cycle pulse.
- INTERRUPT_REQ  out  1  request to PI at level PIA.
- INCR_SEL  out  2  selected counter index, 0..3.
- VECTOR_REQ  out  1  the selected source is the interval timer.
- CLR_OVF  out  4  one-cycle clear strobe to the serviced counter's bit 2.
- INTV_ACK  out  1  one-cycle strobe clearing the interval done flop.
- PENDING  out  5  [0:4] pending flags: TIME, PERF, EBOX, CACHE, INTV.
- LOST  out  4  sticky flag: an overflow arrived while that source was already pending.
- BUSY  out  1  FSM is not IDLE.

Behaviour:
- Reset (synchronous, clk edge with RESET=1):
  - state=IDLE; PENDING=0, LOST=0, timeout counter=0.
  - INTERRUPT_REQ, INCR_SEL, VECTOR_REQ, CLR_OVF, INTV_ACK, BUSY all 0.
  - RESET mid-handshake aborts it silently: no CLR_OVF and no INTV_ACK are issued.
- Pending capture, every cycle:
  - PENDING[i] sets on OVF[i]. PENDING[4] sets while INTV_DONE=1.
  - A source's set and its service clear in the same cycle resolve to set. The new event survives, and LOST stays unchanged.
  - OVF[i] arriving while PENDING[i]=1 and not being cleared sets LOST[i]. LOST clears only on RESET.
- Priority: TIME > PERF > EBOX > CACHE > INTV.
  - Counter winner k: INCR_SEL=k, VECTOR_REQ=0.
  - INTV winner: INCR_SEL=0, VECTOR_REQ=1.
- FSM states: IDLE, REQ, HONORED, COOL.
  - IDLE: if PIA!=0 and any PENDING bit is set, latch the winner into a sel register and go to REQ next cycle. Capture-to-INTERRUPT_REQ latency is 1 cycle after PENDING is visible.
  - REQ: INTERRUPT_REQ=1. The sel register is frozen, so a higher-priority newcomer does not preempt.
    - HONOR → HONORED.
    - PIA→0 → IDLE, with INTERRUPT_REQ dropped the next cycle.
    - Timeout counter reaching HONOR_TMO-1 → COOL.
  - COOL: INTERRUPT_REQ=0 for exactly one cycle, then IDLE; the re-arbitration can pick a newcomer.
  - HONORED: INTERRUPT_REQ=0. INCR_SEL / VECTOR_REQ stay held. PIA changes are ignored.
    - SERVICE_DONE → pulse CLR_OVF[sel] (or INTV_ACK for INTV) in the following cycle.
    - In that same cycle, clear PENDING[sel] (unless re-set per the capture rule), then go to IDLE.
- Outputs outside REQ/HONORED: INCR_SEL and VECTOR_REQ are driven from the live priority encoder of PENDING. The diagnostic read path must see the current winner.
- Stray pulses: HONOR outside REQ and SERVICE_DONE outside HONORED are ignored.
- HONOR and timeout in the same cycle: HONOR wins.
- PENDING[4] is cleared on service but re-sets while INTV_DONE stays high. The INTV_ACK strobe is what drops it.
- BUSY = state!=IDLE.

Decomposition:
- Package mtr_pkg:
  - source index constants SRC_TIME=0, SRC_PERF=1, SRC_EBOX=2, SRC_CACHE=3, SRC_INTV=4;
  - enum mtr_sched_state_t {IDLE, REQ, HONORED, COOL};
  - NSRC=5.
- Sub-module mtr_prio5: combinational 5-input fixed-priority encoder producing index, any, and is_vector. It is reused for both the live outputs and the latched winner.

Test Plan:
1. Single source: PIA=3, OVF[2] pulse.
   - PENDING=00100.
   - INTERRUPT_REQ=1 two cycles after the pulse, INCR_SEL=2.
   - HONOR, then SERVICE_DONE → CLR_OVF=0010 for one cycle, PENDING=0, back to IDLE.
2. Priority and no-preempt: OVF[3] pulse, REQ entered with INCR_SEL=3, then OVF[0].
   - INCR_SEL stays 3 through service.
   - After CLR_OVF[3], a new REQ issues with INCR_SEL=0.
3. Lost and collision:
   - OVF[1] twice while pending → LOST=0100.
   - OVF[1] in the same cycle as its service clear → PENDING[1] stays 1, a second request follows, LOST unchanged.
4. Interval: INTV_DONE=1 alone.
   - VECTOR_REQ=1, INCR_SEL=0.
   - SERVICE_DONE → INTV_ACK pulse, no CLR_OVF.
   - Bench drops INTV_DONE → PENDING[4]=0.
5. Timeout/PIA: HONOR_TMO=4, no HONOR.
   - INTERRUPT_REQ high 4 cycles, low 1 cycle, then high again.
   - PIA→0 in REQ → request drops, PENDING retained.
6. Reset mid-HONORED with SERVICE_DONE in the same cycle:
   - all outputs 0, no CLR_OVF, PENDING=0, LOST=0.

Source files
------------

// File: rtl/mtr_pkg.sv
// Shared definitions for the meter increment scheduler: source indices,
// FSM encoding and the fixed-priority grant helper.
package mtr_pkg;

   localparam int NSRC      = 5;
   localparam int SRC_TIME  = 0;
   localparam int SRC_PERF  = 1;
   localparam int SRC_EBOX  = 2;
   localparam int SRC_CACHE = 3;
   localparam int SRC_INTV  = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      HONORED = 2'd2,
      COOL    = 2'd3
   } mtr_sched_state_t;

   // Lowest index wins: TIME > PERF > EBOX > CACHE > INTV.
   function automatic logic [0:NSRC-1] first_onehot(input logic [0:NSRC-1] req);
      logic [0:NSRC-1] g;
      logic            found;
      g     = '0;
      found = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (req[i] && !found) begin
            g[i]  = 1'b1;
            found = 1'b1;
         end else begin
            g[i]  = 1'b0;
         end
      end
      return g;
   endfunction

endpackage

// File: rtl/mtr_prio5.sv
// Five-source fixed-priority encoder; the interval source reports
// counter index 0 with is_vector set.
module mtr_prio5
   import mtr_pkg::*;
(
   input  logic [0:NSRC-1] req_i,
   output logic [1:0]      idx_o,
   output logic            any_o,
   output logic            is_vector_o
);

   logic [0:NSRC-1] grant;

   assign grant       = first_onehot(req_i);
   assign any_o       = |grant;
   assign is_vector_o = grant[SRC_INTV];
   assign idx_o       = {grant[SRC_EBOX] | grant[SRC_CACHE], grant[SRC_PERF] | grant[SRC_CACHE]};

endmodule

// File: rtl/mtr_incr_sched.sv
// Meter-board service scheduler: latches counter overflows and interval
// done, arbitrates, and runs the PI request/honor/service handshake.
module mtr_incr_sched
   import mtr_pkg::*;
#(
   parameter int HONOR_TMO = 64,
   parameter int TMO_W     = 8
)
(
   input  logic       clk,
   input  logic       RESET,
   input  logic [0:3] OVF,
   input  logic       INTV_DONE,
   input  logic [2:0] PIA,
   input  logic       HONOR,
   input  logic       SERVICE_DONE,
   output logic       INTERRUPT_REQ,
   output logic [1:0] INCR_SEL,
   output logic       VECTOR_REQ,
   output logic [0:3] CLR_OVF,
   output logic       INTV_ACK,
   output logic [0:4] PENDING,
   output logic [0:3] LOST,
   output logic       BUSY
);

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(HONOR_TMO - 1);

   mtr_sched_state_t state_q, state_d;
   logic [0:NSRC-1]  sel_q, sel_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [0:NSRC-1]  pending_q, pending_d;
   logic [0:3]       lost_q, lost_d;
   logic [0:3]       clr_ovf_q, clr_ovf_d;
   logic             intv_ack_q, intv_ack_d;

   logic [0:NSRC-1]  set_vec, clr_vec, avail;
   logic [0:NSRC-1]  arb_grant;
   logic             arb_any;
   logic [1:0]       live_idx, held_idx;
   logic             live_any, held_any, live_vec, held_vec;

   // The service clear lands while the strobe is out; arbitration in that
   // cycle must not re-pick the source being cleared.
   assign set_vec   = {OVF, INTV_DONE};
   assign clr_vec   = {clr_ovf_q, intv_ack_q};
   assign avail     = pending_q & ~clr_vec;
   assign arb_grant = first_onehot(avail);
   assign arb_any   = |avail;

   mtr_prio5 u_live (.req_i(pending_q), .idx_o(live_idx), .any_o(live_any), .is_vector_o(live_vec));
   mtr_prio5 u_held (.req_i(sel_q),     .idx_o(held_idx), .any_o(held_any), .is_vector_o(held_vec));

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (RESET) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         tmo_q      <= '0;
         pending_q  <= '0;
         lost_q     <= '0;
         clr_ovf_q  <= '0;
         intv_ack_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         tmo_q      <= tmo_d;
         pending_q  <= pending_d;
         lost_q     <= lost_d;
         clr_ovf_q  <= clr_ovf_d;
         intv_ack_q <= intv_ack_d;
      end
   end

   // Pending capture: a new event beats a same-cycle service clear.
   always_comb begin
      pending_d = set_vec | (pending_q & ~clr_vec);
      lost_d    = lost_q | (OVF & pending_q[0:3] & ~clr_ovf_q);
   end

   // Next-state logic; COOL re-arbitrates on exit so the request is low one cycle.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      tmo_d      = '0;
      clr_ovf_d  = '0;
      intv_ack_d = 1'b0;
      case (state_q)
         IDLE, COOL: begin
            if ((PIA != 3'd0) && arb_any) begin
               state_d = REQ;
               sel_d   = arb_grant;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (HONOR) begin
               state_d = HONORED;
            end else if (PIA == 3'd0) begin
               state_d = IDLE;
            end else if (tmo_q == TMO_LAST) begin
               state_d = COOL;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         HONORED: begin
            if (SERVICE_DONE) begin
               state_d    = IDLE;
               clr_ovf_d  = sel_q[0:3];
               intv_ack_d = sel_q[SRC_INTV];
            end else begin
               state_d = HONORED;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode: latched winner during the handshake, live winner otherwise.
   always_comb begin
      INCR_SEL   = 2'd0;
      VECTOR_REQ = 1'b0;
      if (((state_q == REQ) || (state_q == HONORED)) && held_any) begin
         INCR_SEL   = held_idx;
         VECTOR_REQ = held_vec;
      end else if (live_any) begin
         INCR_SEL   = live_idx;
         VECTOR_REQ = live_vec;
      end else begin
         INCR_SEL   = 2'd0;
         VECTOR_REQ = 1'b0;
      end
   end

   assign INTERRUPT_REQ = (state_q == REQ);
   assign BUSY          = (state_q != IDLE);
   assign CLR_OVF       = clr_ovf_q;
   assign INTV_ACK      = intv_ack_q;
   assign PENDING       = pending_q;
   assign LOST          = lost_q;

endmodule
